alu_sequencer: RTL and testbench
================================

// Module: alu_sequencer
// PURPOSE
//   Issues ALU operations from a requester onto the shared alu datapath, aligned to the phi machine-cycle clock.
//   Accepts one 8- or 16-bit request over a valid/ready handshake; a 16-bit request runs as two 8-bit passes, low byte first.
//   Holds the result on a valid/ready response port until it is consumed.
//   Sits between the CPU control unit and the alu instance; it is the only driver of the alu operand_A/operand_B/opcode inputs.
// PARAMETERS
//   DATA_WIDTH    gate_boy_pkg::DATA_WIDTH (8)    ALU operand/result width
//   OPCODE_WIDTH  gate_boy_pkg::OPCODE_WIDTH      ALU opcode width
//   ALU_LATENCY   1                               clk cycles from alu inputs changing to alu result valid; >=1, 0 is illegal
// PORTS
//   clk            in   1              system clock (4 MHz)
//   rst            in   1              asynchronous, active-high reset
//   phi            in   1              machine-cycle clock, period 4 clk; sampled in the clk domain
//   req_valid      in   1              request present
//   req_ready      out  1              request accepted when req_valid && req_ready
//   req_wide       in   1              1 = 16-bit op (two passes), 0 = 8-bit op
//   req_opcode     in   OPCODE_WIDTH   opcode for the low/only pass
//   req_opcode_hi  in   OPCODE_WIDTH   opcode for the high pass (ignored when !req_wide)
//   req_a          in   2*DATA_WIDTH   operand A ({hi,lo}; hi ignored when !req_wide)
//   req_b          in   2*DATA_WIDTH   operand B
//   rsp_valid      out  1              result available
//   rsp_ready      in   1              result consumed when rsp_valid && rsp_ready
//   rsp_result     out  2*DATA_WIDTH   {hi,lo}; hi = 0 for narrow ops
//   alu_operand_A  out  DATA_WIDTH     to alu.operand_A (registered)
//   alu_operand_B  out  DATA_WIDTH     to alu.operand_B (registered)
//   alu_opcode     out  OPCODE_WIDTH   to alu.opcode (registered)
//   alu_result     in   DATA_WIDTH     from alu.result
//   busy           out  1              state != IDLE
// BEHAVIOUR
//   Reset (async, any state): state=IDLE; req_ready=1; rsp_valid=0; rsp_result=0; alu_*=0; busy=0; latency counter=0;
//     phi_q=0; latched request cleared. An in-flight operation is aborted and produces no response.
//   phi_rise = phi && !phi_q, where phi_q is phi registered on clk.
//   req_ready = (state==IDLE), combinational. Requests are ignored in every other state.
//   IDLE:    on accept, latch req_* and go to WAIT_LO.
//   WAIT_LO: on phi_rise, register alu_* <= {a[lo], b[lo], req_opcode}; load cnt = ALU_LATENCY; go to EXEC_LO.
//            A phi_rise in the accept cycle itself does not count; the earliest issue is at the next phi_rise.
//   EXEC_LO: cnt decrements each clk. When cnt reaches 0, capture lo <= alu_result.
//            This capture happens exactly ALU_LATENCY clk after the alu_* update.
//            Then go to WAIT_HI if wide, else DONE.
//   WAIT_HI: on phi_rise, register alu_* <= {a[hi], b[hi], req_opcode_hi}; load cnt = ALU_LATENCY; go to EXEC_HI.
//   EXEC_HI: same count as EXEC_LO; capture hi <= alu_result; go to DONE.
//   DONE:    rsp_valid=1; rsp_result stable until the handshake.
//            On rsp_valid && rsp_ready: rsp_valid <= 0 and go to IDLE. req_ready returns 1 the following cycle.
//            If rsp_ready stays low, DONE persists indefinitely and phi edges are ignored.
//   alu_* hold their last driven values outside issue cycles; they never change mid-pass.
//   The capture cycle and a phi_rise may coincide. The capture still occurs; the next pass waits for a strictly later phi_rise.
//   Latency, narrow op: accept -> rsp_valid is at most 4 + ALU_LATENCY + 1 clk. Wide op adds at most 4 + ALU_LATENCY clk.
//   No arithmetic is done here. Flags and carry between passes are the alu's responsibility, selected via req_opcode_hi.
// TESTING (clk 250 ns; phi toggles every 2 clk; bench ALU model: op0 = A+B, op1 = A-B, ALU_LATENCY cycles delay)
//   1 Reset: assert rst mid-period -> all outputs at reset values immediately, before any clk edge; req_ready=1 after release.
//   2 Narrow: req_a=16'h0001, req_b=16'h0001, op0 -> rsp_result=16'h0002.
//     alu_* change only on a phi_rise cycle; latency within bound.
//   3 Wide: a=16'h1234, b=16'h0101, op0/op0 -> rsp_result=16'h1335.
//     The low pass precedes the high pass, and the two alu issues are separated by >=4 clk.
//   4 Backpressure: hold rsp_ready=0 for 20 clk -> rsp_valid and rsp_result (e.g. 16'h00FF from 8'h80+8'h7F) stay stable.
//     A second req_valid during this time is not accepted (req_ready=0).
//   5 Reset mid-op: assert rst during EXEC_HI of a wide op -> no rsp_valid.
//     A subsequent narrow op (8'h05 op1 8'h03) returns 16'h0002.
//   6 Back-to-back with ALU_LATENCY=3: two narrow ops, req_valid held high.
//     The second op is accepted the cycle after the first response handshake, and both results are correct.

Source files
------------

// File: rtl/alu_sequencer.sv
// Sequences one 8- or 16-bit request onto the shared ALU, one byte pass per phi rising edge,
// low byte first, and holds the assembled result on a valid/ready response port.
module alu_sequencer #(
  parameter int DATA_WIDTH   = 8,
  parameter int OPCODE_WIDTH = 4,
  parameter int ALU_LATENCY  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      phi,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_wide,
  input  logic [OPCODE_WIDTH-1:0]   req_opcode,
  input  logic [OPCODE_WIDTH-1:0]   req_opcode_hi,
  input  logic [2*DATA_WIDTH-1:0]   req_a,
  input  logic [2*DATA_WIDTH-1:0]   req_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [2*DATA_WIDTH-1:0]   rsp_result,
  output logic [DATA_WIDTH-1:0]     alu_operand_A,
  output logic [DATA_WIDTH-1:0]     alu_operand_B,
  output logic [OPCODE_WIDTH-1:0]   alu_opcode,
  input  logic [DATA_WIDTH-1:0]     alu_result,
  output logic                      busy
);

  localparam int CW = $clog2(ALU_LATENCY + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAIT_LO = 3'd1;
  localparam logic [2:0] S_EXEC_LO = 3'd2;
  localparam logic [2:0] S_WAIT_HI = 3'd3;
  localparam logic [2:0] S_EXEC_HI = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]              state_q, state_d;
  logic                    phi_q;
  logic                    phi_rise;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    wide_q, wide_d;
  logic [OPCODE_WIDTH-1:0] op_lo_q, op_lo_d;
  logic [OPCODE_WIDTH-1:0] op_hi_q, op_hi_d;
  logic [2*DATA_WIDTH-1:0] a_q, a_d;
  logic [2*DATA_WIDTH-1:0] b_q, b_d;
  logic [DATA_WIDTH-1:0]   alu_a_q, alu_a_d;
  logic [DATA_WIDTH-1:0]   alu_b_q, alu_b_d;
  logic [OPCODE_WIDTH-1:0] alu_op_q, alu_op_d;
  logic [2*DATA_WIDTH-1:0] result_q, result_d;
  logic                    rsp_valid_q, rsp_valid_d;

  // Byte lanes of the latched operands: lane 0 feeds the low pass, lane 1 the high pass.
  logic [DATA_WIDTH-1:0] a_lane [2];
  logic [DATA_WIDTH-1:0] b_lane [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      assign a_lane[gi] = a_q[gi*DATA_WIDTH +: DATA_WIDTH];
      assign b_lane[gi] = b_q[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  assign phi_rise = phi && !phi_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wide_d      = wide_q;
    op_lo_d     = op_lo_q;
    op_hi_d     = op_hi_q;
    a_d         = a_q;
    b_d         = b_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    result_d    = result_q;
    rsp_valid_d = rsp_valid_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          wide_d   = req_wide;
          op_lo_d  = req_opcode;
          op_hi_d  = req_opcode_hi;
          a_d      = req_a;
          b_d      = req_b;
          result_d = '0;
          state_d  = S_WAIT_LO;
        end
      end
      S_WAIT_LO: begin
        if (phi_rise) begin
          alu_a_d  = a_lane[0];
          alu_b_d  = b_lane[0];
          alu_op_d = op_lo_q;
          cnt_d    = CW'(ALU_LATENCY);
          state_d  = S_EXEC_LO;
        end
      end
      S_EXEC_LO: begin
        // Capturing on the cnt==1 edge lands exactly ALU_LATENCY clk after the issue edge.
        if (cnt_q == CW'(1)) begin
          cnt_d                  = '0;
          result_d[DATA_WIDTH-1:0] = alu_result;
          state_d                = wide_q ? S_WAIT_HI : S_DONE;
          rsp_valid_d            = !wide_q;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_WAIT_HI: begin
        if (phi_rise) begin
          alu_a_d  = a_lane[1];
          alu_b_d  = b_lane[1];
          alu_op_d = op_hi_q;
          cnt_d    = CW'(ALU_LATENCY);
          state_d  = S_EXEC_HI;
        end
      end
      S_EXEC_HI: begin
        if (cnt_q == CW'(1)) begin
          cnt_d                                   = '0;
          result_d[2*DATA_WIDTH-1:DATA_WIDTH]     = alu_result;
          state_d                                 = S_DONE;
          rsp_valid_d                             = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      phi_q       <= 1'b0;
      cnt_q       <= '0;
      wide_q      <= 1'b0;
      op_lo_q     <= '0;
      op_hi_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      result_q    <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phi_q       <= phi;
      cnt_q       <= cnt_d;
      wide_q      <= wide_d;
      op_lo_q     <= op_lo_d;
      op_hi_q     <= op_hi_d;
      a_q         <= a_d;
      b_q         <= b_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      result_q    <= result_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign req_ready     = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign rsp_valid     = rsp_valid_q;
  assign rsp_result    = result_q;
  assign alu_operand_A = alu_a_q;
  assign alu_operand_B = alu_b_q;
  assign alu_opcode    = alu_op_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: one instance with a single-cycle ALU, one with a three-cycle ALU,
// checked against a byte-wise reference of the requested operation.
module tb_alu_sequencer;
  localparam int DW = 8;
  localparam int OW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic phi = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #125 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // phi toggles every second clk, away from the clk edges
  int ph_cnt = 0;
  always begin
    @(posedge clk);
    #60;
    ph_cnt = ph_cnt + 1;
    if (ph_cnt % 2 == 0) phi = ~phi;
  end

  function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'd0:    alu_f = a + b;
      4'd1:    alu_f = a - b;
      default: alu_f = a ^ b;
    endcase
  endfunction

  function automatic logic [15:0] ref_op(input logic w, input logic [3:0] op, input logic [3:0] oph,
                                         input logic [15:0] a, input logic [15:0] b);
    if (w) ref_op = {alu_f(oph, a[15:8], b[15:8]), alu_f(op, a[7:0], b[7:0])};
    else   ref_op = {8'h00, alu_f(op, a[7:0], b[7:0])};
  endfunction

  // ---------------- instance with ALU_LATENCY = 1 ----------------
  logic        req_valid = 0, req_wide = 0, rsp_ready = 0;
  logic [3:0]  req_opcode = 0, req_opcode_hi = 0;
  logic [15:0] req_a = 0, req_b = 0;
  logic        req_ready, rsp_valid, busy;
  logic [15:0] rsp_result;
  logic [7:0]  alu_a, alu_b, alu_res;
  logic [3:0]  alu_op;

  assign alu_res = alu_f(alu_op, alu_a, alu_b);

  alu_sequencer #(.DATA_WIDTH(DW), .OPCODE_WIDTH(OW), .ALU_LATENCY(1)) dut (
    .clk(clk), .rst(rst), .phi(phi),
    .req_valid(req_valid), .req_ready(req_ready), .req_wide(req_wide),
    .req_opcode(req_opcode), .req_opcode_hi(req_opcode_hi), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .alu_operand_A(alu_a), .alu_operand_B(alu_b), .alu_opcode(alu_op),
    .alu_result(alu_res), .busy(busy)
  );

  // ---------------- instance with ALU_LATENCY = 3 ----------------
  logic        req_valid3 = 0, req_wide3 = 0, rsp_ready3 = 0;
  logic [3:0]  req_opcode3 = 0, req_opcode_hi3 = 0;
  logic [15:0] req_a3 = 0, req_b3 = 0;
  logic        req_ready3, rsp_valid3, busy3;
  logic [15:0] rsp_result3;
  logic [7:0]  alu_a3, alu_b3, alu_res3, s1_a, s1_b, s2_a, s2_b;
  logic [3:0]  alu_op3, s1_op, s2_op;

  // two register stages: result valid three clk after the inputs change
  always @(posedge clk) begin
    s1_a <= alu_a3; s1_b <= alu_b3; s1_op <= alu_op3;
    s2_a <= s1_a;   s2_b <= s1_b;   s2_op <= s1_op;
  end
  assign alu_res3 = alu_f(s2_op, s2_a, s2_b);

  alu_sequencer #(.DATA_WIDTH(DW), .OPCODE_WIDTH(OW), .ALU_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .phi(phi),
    .req_valid(req_valid3), .req_ready(req_ready3), .req_wide(req_wide3),
    .req_opcode(req_opcode3), .req_opcode_hi(req_opcode_hi3), .req_a(req_a3), .req_b(req_b3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_result(rsp_result3),
    .alu_operand_A(alu_a3), .alu_operand_B(alu_b3), .alu_opcode(alu_op3),
    .alu_result(alu_res3), .busy(busy3)
  );

  // ---------------- issue monitor (latency-1 instance) ----------------
  // The DUT sees at posedge n the phi value present at negedge n-1, and its phi_q holds the
  // value from negedge n-2; an issue at posedge n therefore needs p1=1, p2=0.
  int        phi_viol = 0;
  int        settle = 3;
  logic      p1 = 0, p2 = 0;
  logic [7:0] last_a = 0, last_b = 0;
  logic [3:0] last_op = 0;
  int         iss_cyc_q[$];
  logic [7:0] iss_a_q[$];

  always @(negedge clk) begin
    if (rst) begin
      settle = 3;
    end else begin
      if ((alu_a !== last_a) || (alu_b !== last_b) || (alu_op !== last_op)) begin
        if (settle == 0 && !(p1 && !p2)) phi_viol = phi_viol + 1;
        iss_cyc_q.push_back(cyc);
        iss_a_q.push_back(alu_a);
      end
      if (settle > 0) settle = settle - 1;
    end
    last_a = alu_a; last_b = alu_b; last_op = alu_op;
    p2 = p1; p1 = phi;
  end

  // ---------------- drivers ----------------
  task automatic send_req(input logic w, input logic [3:0] op, input logic [3:0] oph,
                          input logic [15:0] a, input logic [15:0] b,
                          output int acc_cyc, output bit to);
    @(negedge clk);
    req_wide = w; req_opcode = op; req_opcode_hi = oph; req_a = a; req_b = b;
    req_valid = 1'b1;
    to = 1'b1;
    acc_cyc = 0;
    for (int i = 0; i < 50; i++) begin
      if (req_ready) begin
        @(negedge clk);
        acc_cyc = cyc;
        to = 1'b0;
        break;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int limit, output int seen_cyc, output bit to);
    to = 1'b1;
    seen_cyc = 0;
    for (int i = 0; i < limit; i++) begin
      if (rsp_valid) begin
        seen_cyc = cyc;
        to = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic take_rsp(output logic [15:0] res);
    res = rsp_result;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    #40;
    rst = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
    n_cmp++; if (rsp_result !== 16'h0) begin n_fail++; $display("FAIL reset_rsp_result got=%h want=0000", rsp_result); end
    n_cmp++; if (alu_a !== 8'h0)      begin n_fail++; $display("FAIL reset_alu_a got=%h want=00", alu_a); end
    n_cmp++; if (alu_b !== 8'h0)      begin n_fail++; $display("FAIL reset_alu_b got=%h want=00", alu_b); end
    n_cmp++; if (alu_op !== 4'h0)     begin n_fail++; $display("FAIL reset_alu_op got=%h want=0", alu_op); end
    n_cmp++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk); @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_release_ready got=%b want=1", req_ready); end
    n_cmp++; if (req_ready3 !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready3 got=%b want=1", req_ready3); end
    $display("reset: outputs checked during and after reset");
  endtask

  task automatic test_narrow();
    int acc, seen; bit to1, to2; logic [15:0] res;
    iss_cyc_q.delete(); iss_a_q.delete();
    send_req(1'b0, 4'd0, 4'd0, 16'h0001, 16'h0001, acc, to1);
    wait_rsp(30, seen, to2);
    take_rsp(res);
    n_cmp++; if (to1 || to2) begin n_fail++; $display("FAIL narrow_timeout got=%b%b want=00", to1, to2); end
    n_cmp++; if (res !== 16'h0002) begin n_fail++; $display("FAIL narrow_result got=%h want=0002", res); end
    n_cmp++; if (seen - acc > 6) begin n_fail++; $display("FAIL narrow_latency got=%0d want<=6", seen - acc); end
    n_cmp++; if (iss_a_q.size() != 1) begin n_fail++; $display("FAIL narrow_issues got=%0d want=1", iss_a_q.size()); end
    n_cmp++; if (phi_viol != 0) begin n_fail++; $display("FAIL narrow_phi_align got=%0d want=0", phi_viol); end
    $display("narrow: a=0001 b=0001 op0 res=%h lat=%0d", res, seen - acc);
  endtask

  task automatic test_wide();
    int acc, seen; bit to1, to2; logic [15:0] res;
    iss_cyc_q.delete(); iss_a_q.delete();
    send_req(1'b1, 4'd0, 4'd0, 16'h1234, 16'h0101, acc, to1);
    wait_rsp(40, seen, to2);
    take_rsp(res);
    n_cmp++; if (to1 || to2) begin n_fail++; $display("FAIL wide_timeout got=%b%b want=00", to1, to2); end
    n_cmp++; if (res !== 16'h1335) begin n_fail++; $display("FAIL wide_result got=%h want=1335", res); end
    n_cmp++; if (seen - acc > 11) begin n_fail++; $display("FAIL wide_latency got=%0d want<=11", seen - acc); end
    n_cmp++;
    if (iss_a_q.size() != 2) begin
      n_fail++; $display("FAIL wide_issues got=%0d want=2", iss_a_q.size());
    end else begin
      n_cmp++; if (iss_a_q[0] !== 8'h34) begin n_fail++; $display("FAIL wide_lo_first got=%h want=34", iss_a_q[0]); end
      n_cmp++; if (iss_a_q[1] !== 8'h12) begin n_fail++; $display("FAIL wide_hi_second got=%h want=12", iss_a_q[1]); end
      n_cmp++; if (iss_cyc_q[1] - iss_cyc_q[0] < 4) begin n_fail++; $display("FAIL wide_gap got=%0d want>=4", iss_cyc_q[1] - iss_cyc_q[0]); end
    end
    $display("wide: a=1234 b=0101 op0/op0 res=%h lat=%0d", res, seen - acc);
  endtask

  task automatic test_random();
    for (int k = 0; k < 10; k++) begin
      int acc, seen, bound; bit to1, to2; logic [15:0] res, exp, a, b; logic w; logic [3:0] op, oph;
      w = 1'($urandom_range(0, 1));
      op = 4'($urandom_range(0, 2));
      oph = 4'($urandom_range(0, 2));
      a = 16'($urandom);
      b = 16'($urandom);
      exp = ref_op(w, op, oph, a, b);
      bound = w ? 11 : 6;
      send_req(w, op, oph, a, b, acc, to1);
      wait_rsp(40, seen, to2);
      take_rsp(res);
      n_cmp++; if (to1 || to2) begin n_fail++; $display("FAIL random_timeout k=%0d got=%b%b want=00", k, to1, to2); end
      n_cmp++; if (res !== exp) begin n_fail++; $display("FAIL random_result k=%0d got=%h want=%h", k, res, exp); end
      n_cmp++; if (seen - acc > bound) begin n_fail++; $display("FAIL random_latency k=%0d got=%0d want<=%0d", k, seen - acc, bound); end
      $display("random: w=%0d op=%0d/%0d a=%h b=%h res=%h lat=%0d", w, op, oph, a, b, res, seen - acc);
    end
    n_cmp++; if (phi_viol != 0) begin n_fail++; $display("FAIL random_phi_align got=%0d want=0", phi_viol); end
  endtask

  task automatic test_backpressure();
    int acc, seen; bit to1, to2; logic [15:0] res;
    send_req(1'b0, 4'd0, 4'd0, 16'h0080, 16'h007F, acc, to1);
    wait_rsp(30, seen, to2);
    n_cmp++; if (to1 || to2) begin n_fail++; $display("FAIL bp_timeout got=%b%b want=00", to1, to2); end
    req_wide = 1'b0; req_opcode = 4'd1; req_a = 16'h0009; req_b = 16'h0004;
    req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid i=%0d got=%b want=1", i, rsp_valid); end
      n_cmp++; if (rsp_result !== 16'h00FF) begin n_fail++; $display("FAIL bp_result i=%0d got=%h want=00ff", i, rsp_result); end
      n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_req_ready i=%0d got=%b want=0", i, req_ready); end
      @(negedge clk);
    end
    req_valid = 1'b0;
    take_rsp(res);
    n_cmp++; if (res !== 16'h00FF) begin n_fail++; $display("FAIL bp_final got=%h want=00ff", res); end
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after got=%b want=1", req_ready); end
    $display("backpressure: a=0080 b=007F op0 held 20 clk res=%h", res);
  endtask

  task automatic test_reset_midop();
    int acc, seen, hits; bit to1, to2, found; logic [15:0] res;
    send_req(1'b1, 4'd0, 4'd0, 16'h1234, 16'h0101, acc, to1);
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (alu_a === 8'h12) begin found = 1'b1; break; end
      @(negedge clk);
    end
    n_cmp++; if (to1 || !found) begin n_fail++; $display("FAIL midop_reach_hi got=%b%b want=01", to1, found); end
    #20;
    rst = 1'b1;
    #1;
    n_cmp++; if (alu_a !== 8'h00) begin n_fail++; $display("FAIL midop_alu_a got=%h want=00", alu_a); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midop_busy got=%b want=0", busy); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    hits = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) hits++;
    end
    n_cmp++; if (hits != 0) begin n_fail++; $display("FAIL midop_no_rsp got=%0d want=0", hits); end
    send_req(1'b0, 4'd1, 4'd0, 16'h0005, 16'h0003, acc, to1);
    wait_rsp(30, seen, to2);
    take_rsp(res);
    n_cmp++; if (to1 || to2) begin n_fail++; $display("FAIL midop_next_timeout got=%b%b want=00", to1, to2); end
    n_cmp++; if (res !== 16'h0002) begin n_fail++; $display("FAIL midop_next_result got=%h want=0002", res); end
    $display("reset_midop: aborted wide op, then 05 op1 03 res=%h", res);
  endtask

  task automatic test_back_to_back();
    logic [15:0] a1, b1, a2, b2, e1, e2, r1, r2;
    logic [3:0]  o1, o2;
    int n_acc, n_hs, acc2, hs1;
    bit acc_p, hs_p;
    logic [15:0] grab;
    a1 = 16'($urandom); b1 = 16'($urandom); o1 = 4'($urandom_range(0, 1));
    a2 = 16'($urandom); b2 = 16'($urandom); o2 = 4'($urandom_range(0, 1));
    e1 = ref_op(1'b0, o1, 4'd0, a1, b1);
    e2 = ref_op(1'b0, o2, 4'd0, a2, b2);
    n_acc = 0; n_hs = 0; acc2 = -1; hs1 = -100; acc_p = 0; hs_p = 0; grab = '0; r1 = 'x; r2 = 'x;
    @(negedge clk);
    req_wide3 = 1'b0; req_opcode3 = o1; req_a3 = a1; req_b3 = b1;
    req_valid3 = 1'b1; rsp_ready3 = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (acc_p) begin
        n_acc++;
        if (n_acc == 1) begin
          req_opcode3 = o2; req_a3 = a2; req_b3 = b2;
        end else begin
          acc2 = cyc;
          req_valid3 = 1'b0;
        end
      end
      if (hs_p) begin
        n_hs++;
        if (n_hs == 1) begin r1 = grab; hs1 = cyc; end
        else r2 = grab;
      end
      if (n_hs == 2) break;
      acc_p = req_valid3 && req_ready3;
      hs_p  = rsp_valid3 && rsp_ready3;
      if (hs_p) grab = rsp_result3;
      @(negedge clk);
    end
    req_valid3 = 1'b0; rsp_ready3 = 1'b0;
    n_cmp++; if (n_acc != 2) begin n_fail++; $display("FAIL b2b_accepts got=%0d want=2", n_acc); end
    n_cmp++; if (n_hs != 2) begin n_fail++; $display("FAIL b2b_handshakes got=%0d want=2", n_hs); end
    n_cmp++; if (r1 !== e1) begin n_fail++; $display("FAIL b2b_result1 got=%h want=%h", r1, e1); end
    n_cmp++; if (r2 !== e2) begin n_fail++; $display("FAIL b2b_result2 got=%h want=%h", r2, e2); end
    n_cmp++; if (acc2 != hs1 + 1) begin n_fail++; $display("FAIL b2b_accept_timing got=%0d want=%0d", acc2, hs1 + 1); end
    $display("back_to_back: op1 %h,%h res=%h  op2 %h,%h res=%h", a1, b1, r1, a2, b2, r2);
  endtask

  initial begin
    #(250 * 20000);
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_narrow();
    test_wide();
    test_random();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
